// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults for the multi-ported register file.
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_IDX = 0;
endpackage

// File: rtl/regfile_rport.sv
// regfile_rport: one registered read port with write bypass and reservation busy check.
module regfile_rport
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_enable,
  input  logic [AW-1:0]   i_select,
  input  logic [XLEN-1:0] i_rdata,
  input  logic            i_pend,
  input  logic            i_wen,
  input  logic [AW-1:0]   i_wsel,
  input  logic [XLEN-1:0] i_wval,
  output logic [XLEN-1:0] o_out,
  output logic            o_valid,
  output logic            o_busy
);
  logic            w_hit;
  logic            w_ok;
  logic [XLEN-1:0] r_out;
  logic            r_valid;
  logic            r_busy;
  // A same-cycle write overrides any prior reservation of the read index.
  assign w_hit = i_wen && (i_wsel == i_select) && (i_select != AW'(ZERO_IDX));
  assign w_ok  = i_enable && (w_hit || !i_pend);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= w_ok;
      r_busy  <= i_enable && !w_ok;
      if (w_ok) r_out <= w_hit ? i_wval : i_rdata;
    end
  end
  assign o_out   = r_out;
  assign o_valid = r_valid;
  assign o_busy  = r_busy;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: two-read/one-write register file with per-register reservation scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_enable,
  input  logic [AW-1:0]    r0_select,
  output logic [XLEN-1:0]  r0_out,
  output logic             r0_valid,
  output logic             r0_busy,
  input  logic             r1_enable,
  input  logic [AW-1:0]    r1_select,
  output logic [XLEN-1:0]  r1_out,
  output logic             r1_valid,
  output logic             r1_busy,
  input  logic             w_enable,
  input  logic [AW-1:0]    w_select,
  input  logic [XLEN-1:0]  w_val,
  input  logic             rsv_enable,
  input  logic [AW-1:0]    rsv_select,
  output logic [NREGS-1:0] pending
);
  logic [XLEN-1:0]  r_mem [NREGS];
  logic [NREGS-1:0] r_pending;
  logic             w_wr;
  logic             w_rsv;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;
  assign w_wr  = w_enable && (w_select != AW'(ZERO_IDX));
  assign w_rsv = rsv_enable && (rsv_select != AW'(ZERO_IDX));
  assign w_set = NREGS'(w_rsv) << rsv_select;
  assign w_clr = NREGS'(w_wr) << w_select;
  // Set is applied after clear so a new producer reserved alongside a write keeps the bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
      r_pending <= '0;
    end else begin
      if (w_wr) r_mem[w_select] <= w_val;
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end
  assign pending = r_pending;
  regfile_rport #(.XLEN(XLEN), .AW(AW)) u_rport0 (
    .clk(clk), .rst_n(rst_n), .i_enable(r0_enable), .i_select(r0_select),
    .i_rdata(r_mem[r0_select]), .i_pend(r_pending[r0_select]),
    .i_wen(w_enable), .i_wsel(w_select), .i_wval(w_val),
    .o_out(r0_out), .o_valid(r0_valid), .o_busy(r0_busy)
  );
  regfile_rport #(.XLEN(XLEN), .AW(AW)) u_rport1 (
    .clk(clk), .rst_n(rst_n), .i_enable(r1_enable), .i_select(r1_select),
    .i_rdata(r_mem[r1_select]), .i_pend(r_pending[r1_select]),
    .i_wen(w_enable), .i_wsel(w_select), .i_wval(w_val),
    .o_out(r1_out), .o_valid(r1_valid), .o_busy(r1_busy)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random checks of regfile_mp against a behavioural model.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_enable, r1_enable, w_enable, rsv_enable;
  logic [4:0]  r0_select, r1_select, w_select, rsv_select;
  logic [31:0] w_val, r0_out, r1_out;
  logic        r0_valid, r0_busy, r1_valid, r1_busy;
  logic [31:0] pending;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_mem [32];
  bit          m_pend [32];
  logic [31:0] e_out [2];
  bit          e_val [2];
  bit          e_busy [2];

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n),
    .r0_enable(r0_enable), .r0_select(r0_select), .r0_out(r0_out), .r0_valid(r0_valid), .r0_busy(r0_busy),
    .r1_enable(r1_enable), .r1_select(r1_select), .r1_out(r1_out), .r1_valid(r1_valid), .r1_busy(r1_busy),
    .w_enable(w_enable), .w_select(w_select), .w_val(w_val),
    .rsv_enable(rsv_enable), .rsv_select(rsv_select), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = '0;
      m_pend[i] = 0;
    end
    for (int p = 0; p < 2; p++) begin
      e_out[p] = '0;
      e_val[p] = 0;
      e_busy[p] = 0;
    end
  endtask

  task automatic model_edge();
    bit         en [2];
    logic [4:0] sel [2];
    en[0] = r0_enable; en[1] = r1_enable;
    sel[0] = r0_select; sel[1] = r1_select;
    for (int p = 0; p < 2; p++) begin
      e_val[p] = 0;
      e_busy[p] = 0;
      if (en[p]) begin
        if (w_enable && w_select == sel[p] && sel[p] != 0) begin
          e_out[p] = w_val;
          e_val[p] = 1;
        end else if (m_pend[sel[p]]) begin
          e_busy[p] = 1;
        end else begin
          e_out[p] = m_mem[sel[p]];
          e_val[p] = 1;
        end
      end
    end
    if (w_enable && w_select != 0) begin
      m_mem[w_select] = w_val;
      m_pend[w_select] = 0;
    end
    if (rsv_enable && rsv_select != 0) m_pend[rsv_select] = 1;
  endtask

  task automatic check_all();
    logic [31:0] pv;
    for (int i = 0; i < 32; i++) pv[i] = m_pend[i];
    chk("r0_out", r0_out, e_out[0]);
    chk("r0_valid", r0_valid, e_val[0]);
    chk("r0_busy", r0_busy, e_busy[0]);
    chk("r1_out", r1_out, e_out[1]);
    chk("r1_valid", r1_valid, e_val[1]);
    chk("r1_busy", r1_busy, e_busy[1]);
    chk("pending", pending, pv);
  endtask

  task automatic idle();
    r0_enable = 0; r1_enable = 0; w_enable = 0; rsv_enable = 0;
    r0_select = 0; r1_select = 0; w_select = 0; rsv_select = 0; w_val = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_r0_out"}, r0_out, 0);
    chk({tag, "_r1_out"}, r1_out, 0);
    chk({tag, "_flags"}, {r0_valid, r0_busy, r1_valid, r1_busy}, 0);
    chk({tag, "_pending"}, pending, 0);
  endtask

  initial begin
    rst_n = 0;
    idle();
    model_reset();
    #12;
    check_reset_outputs("rst");
    rst_n = 1;
    r0_enable = 1; r0_select = 5; r1_enable = 1; r1_select = 5;
    cyc();
    chk("rd5_r0_valid", r0_valid, 1);
    chk("rd5_r1_valid", r1_valid, 1);
    chk("rd5_out", {r0_out, r1_out}, 0);
    idle(); w_enable = 1; w_select = 3; w_val = 32'hDEADBEEF;
    cyc();
    idle(); r0_enable = 1; r0_select = 3;
    cyc();
    chk("wr3_out", r0_out, 32'hDEADBEEF);
    chk("wr3_valid", r0_valid, 1);
    idle(); w_enable = 1; w_select = 7; w_val = 32'h1234; r1_enable = 1; r1_select = 7;
    cyc();
    chk("byp7_out", r1_out, 32'h1234);
    chk("byp7_valid", r1_valid, 1);
    idle(); w_enable = 1; w_select = 0; w_val = 32'hFFFFFFFF;
    cyc();
    idle(); r0_enable = 1; r1_enable = 1;
    cyc();
    chk("x0_out", {r0_out, r1_out}, 0);
    idle(); rsv_enable = 1; rsv_select = 0;
    cyc();
    chk("x0_pend", pending[0], 0);
    idle(); rsv_enable = 1; rsv_select = 9;
    cyc();
    chk("rsv9_pend", pending[9], 1);
    idle(); r0_enable = 1; r0_select = 9;
    cyc();
    chk("busy9_flags", {r0_busy, r0_valid}, 2'b10);
    chk("busy9_out_held", r0_out, 0);
    idle(); r0_enable = 1; r0_select = 9; w_enable = 1; w_select = 9; w_val = 32'h55;
    cyc();
    chk("done9_out", r0_out, 32'h55);
    chk("done9_valid", r0_valid, 1);
    chk("done9_pend", pending[9], 0);
    idle(); rsv_enable = 1; rsv_select = 4; w_enable = 1; w_select = 4; w_val = 32'hA5;
    cyc();
    chk("conf4_pend", pending[4], 1);
    idle(); r0_enable = 1; r0_select = 4;
    cyc();
    chk("conf4_busy", r0_busy, 1);
    idle(); r0_enable = 1; r0_select = 3; r1_enable = 1; r1_select = 7;
    rsv_enable = 1; rsv_select = 12;
    cyc();
    chk("pre_rst_out", r0_out, 32'hDEADBEEF);
    #2 rst_n = 0;
    #1 check_reset_outputs("midrst");
    #4 check_reset_outputs("midrst_hold");
    rst_n = 1;
    model_reset();
    idle();
    for (int n = 0; n < 400; n++) begin
      r0_enable = 1'($urandom_range(0, 1));
      r1_enable = 1'($urandom_range(0, 1));
      w_enable = 1'($urandom_range(0, 1));
      rsv_enable = ($urandom_range(0, 2) == 0);
      r0_select = 5'($urandom_range(0, 7));
      r1_select = 5'($urandom_range(0, 7));
      w_select = 5'($urandom_range(0, 7));
      rsv_select = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) r0_select = 5'($urandom);
      w_val = $urandom;
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32, data width of each register in bits.
REQ-002 Parameter NREGS, default 32, number of architectural registers; SHALL be a power of two and at least 2.
REQ-003 Derived constant AW = $clog2(NREGS), the register-select width.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 r0_enable / r1_enable  input  1  read request, port 0 / port 1.
REQ-007 r0_select / r1_select  input  AW  register index read by port 0 / port 1.
REQ-008 r0_out / r1_out  output  XLEN  registered read data, port 0 / port 1.
REQ-009 r0_valid / r1_valid  output  1  one-cycle pulse: rN_out holds the requested value.
REQ-010 r0_busy / r1_busy  output  1  one-cycle pulse: request refused because the register is reserved.
REQ-011 w_enable  input  1  write request.
REQ-012 w_select  input  AW  write index.
REQ-013 w_val  input  XLEN  write data.
REQ-014 rsv_enable  input  1  reserve request: marks a register as having a pending producer.
REQ-015 rsv_select  input  AW  index to reserve.
REQ-016 pending  output  NREGS  current reservation bit per register; bit 0 is always 0.

Function
REQ-017 Register 0 SHALL always read as zero; writes and reservations to index 0 SHALL be ignored.
REQ-018 A write with w_enable=1 and w_select!=0 SHALL update storage at that clock edge.
REQ-019 The same write SHALL clear pending[w_select], unless REQ-024 applies.
REQ-020 Read latency SHALL be exactly one cycle: a request sampled at edge N drives rN_out and rN_valid/rN_busy after edge N.
REQ-021 Each read port SHALL resolve independently; both ports may select the same index in the same cycle.
REQ-022 Read of an unreserved register: rN_valid=1, rN_busy=0, rN_out = stored value.
REQ-023 Write bypass: if a write to the read index is sampled in the same cycle, rN_out SHALL return w_val with rN_valid=1, even if that register was pending.
REQ-024 Simultaneous rsv and write to the same index: storage takes w_val and pending stays 1 (new producer wins).
REQ-025 Read of a pending register with no same-cycle write to it: rN_valid=0, rN_busy=1; rN_out SHALL hold its previous value.
REQ-026 A simultaneous reservation of the read index SHALL NOT affect that read; only the prior pending state is used.
REQ-027 With rN_enable=0, rN_valid=0 and rN_busy=0 on the next cycle, and rN_out SHALL hold its value.
REQ-028 Reserving an already-pending register SHALL leave pending=1; there is no counting.
REQ-029 Handshake: the block has no backpressure; requesters retry busy reads; every request completes in exactly one cycle.

Reset
REQ-030 While rst_n=0, all storage SHALL be 0 and pending SHALL be all 0.
REQ-031 While rst_n=0, r0_out and r1_out SHALL be 0, and all valid and busy outputs SHALL be 0.
REQ-032 Reset assertion mid-operation SHALL take effect immediately, asynchronously, and discard in-flight reads.
REQ-033 After rst_n rises, the first request SHALL be honoured at the first rising clock edge.

Structure
REQ-034 Shared package regfile_pkg SHALL hold the default XLEN and NREGS constants and the zero-register index constant.
REQ-035 One sub-module, regfile_rport, SHALL implement a single read port: bypass mux, busy check and output registers.
REQ-036 regfile_mp SHALL instantiate regfile_rport twice.
REQ-037 Storage and the pending vector SHALL reside in regfile_mp.

Verification
REQ-038 Reset then read: reset, read x5 on both ports -> both valid=1, out=0, pending=0.
REQ-039 Write then read: write x3=0xDEADBEEF, read x3 next cycle -> r0_out=0xDEADBEEF, valid=1.
REQ-040 Same-cycle bypass: write x7=0x1234 while r1 reads x7 -> r1_out=0x1234 one cycle later, r1_valid=1.
REQ-041 Zero register: write x0=0xFFFFFFFF, then read x0 -> out=0; rsv x0 -> pending[0]=0.
REQ-042 Scoreboard, refuse then complete:
- rsv x9, then read x9 -> busy=1, valid=0, out unchanged;
- write x9=0x55 while reading x9 -> valid=1, out=0x55, pending[9]=0.
REQ-043 Conflict and mid-operation reset:
- rsv and write x4=0xA5 in the same cycle -> pending[4]=1, and a later read of x4 returns busy;
- assert rst_n mid-read -> outputs 0 immediately.
